// File: rtl/apm_p_norm_round.sv
// Normalise the APM P product, round RNE to MANT_W bits and adjust the exponent.
// 2-cycle latency; valid/ready pipeline, outputs hold while stalled, full throughput.
module apm_p_norm_round #(
    parameter int P_W      = 48,
    parameter int FRAC_POS = 46,
    parameter int MANT_W   = 24,
    parameter int EXP_W    = 8,
    parameter int TAG_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [P_W-1:0]     p_in,
    input  logic [EXP_W+1:0]   exp_in,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MANT_W-1:0]  mant_out,
    output logic [EXP_W-1:0]   exp_out,
    output logic [TAG_W-1:0]   tag_out,
    output logic               zero,
    output logic               ovf,
    output logic               unf
);
    localparam int LZ_W    = $clog2(P_W + 1);
    localparam int EXP_MAX = (1 << EXP_W) - 2;

    logic               s1_v;
    logic [P_W-1:0]     s1_p;
    logic [EXP_W+1:0]   s1_exp;
    logic [TAG_W-1:0]   s1_tag;
    logic [LZ_W-1:0]    s1_lz;
    logic               s1_zero;
    logic               s2_rdy;
    logic [LZ_W-1:0]    lz;

    assign s2_rdy   = !out_valid || out_ready;
    assign in_ready = !s1_v || s2_rdy;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        lz = LZ_W'(P_W);
        for (int i = 0; i < P_W; i++) begin
            if (p_in[i]) lz = LZ_W'(P_W - 1 - i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_p    <= '0;
            s1_exp  <= '0;
            s1_tag  <= '0;
            s1_lz   <= '0;
            s1_zero <= 1'b0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_p    <= p_in;
                s1_exp  <= exp_in;
                s1_tag  <= tag_in;
                s1_lz   <= lz;
                s1_zero <= (p_in == '0);
            end
        end
    end

    logic [P_W-1:0]     n;
    logic [MANT_W-1:0]  m;
    logic               g;
    logic               s;
    logic               rnd_up;
    logic [MANT_W:0]    m_sum;
    logic               carry;
    logic [MANT_W-1:0]  mant_rnd;
    logic [EXP_W+1:0]   e_calc;
    logic               c_zero;
    logic               c_ovf;
    logic               c_unf;
    logic [MANT_W-1:0]  mant_c;
    logic [EXP_W-1:0]   exp_c;

    always_comb begin
        n        = s1_p << s1_lz;
        m        = n[P_W-1 -: MANT_W];
        g        = n[P_W-1-MANT_W];
        s        = |n[P_W-2-MANT_W:0];
        rnd_up   = g && (s || m[0]);
        m_sum    = {1'b0, m} + {{MANT_W{1'b0}}, rnd_up};
        carry    = m_sum[MANT_W];
        // On carry-out the low bits are already zero; only the hidden bit needs restoring.
        mant_rnd = carry ? {1'b1, {(MANT_W-1){1'b0}}} : m_sum[MANT_W-1:0];
        e_calc   = s1_exp + (EXP_W+2)'(P_W - 1 - FRAC_POS)
                 - (EXP_W+2)'(s1_lz) + (EXP_W+2)'(carry);
        c_zero   = s1_zero;
        c_ovf    = !c_zero && ($signed(e_calc) > $signed((EXP_W+2)'(EXP_MAX)));
        c_unf    = !c_zero && !c_ovf && ($signed(e_calc) < $signed((EXP_W+2)'(1)));
        mant_c   = (c_zero || c_ovf || c_unf) ? '0 : mant_rnd;
        if (c_zero || c_unf)
            exp_c = '0;
        else if (c_ovf)
            exp_c = '1;
        else
            exp_c = e_calc[EXP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            mant_out  <= '0;
            exp_out   <= '0;
            tag_out   <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (s2_rdy) begin
            out_valid <= s1_v;
            if (s1_v) begin
                mant_out <= mant_c;
                exp_out  <= exp_c;
                tag_out  <= s1_tag;
                zero     <= c_zero;
                ovf      <= c_ovf;
                unf      <= c_unf;
            end
        end
    end
endmodule

// File: tb/tb_apm_p_norm_round.sv
// Directed and small random vectors for apm_p_norm_round with an in-order result scoreboard.
module tb_apm_p_norm_round;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] p_in;
    logic [9:0]  exp_in;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] mant_out;
    logic [7:0]  exp_out;
    logic [3:0]  tag_out;
    logic        zero, ovf, unf;

    always #5 clk = ~clk;

    apm_p_norm_round dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .p_in(p_in), .exp_in(exp_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mant_out(mant_out), .exp_out(exp_out), .tag_out(tag_out),
        .zero(zero), .ovf(ovf), .unf(unf)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_sent = 0;
    int n_out = 0;
    logic [38:0] exp_q[$];
    logic [38:0] obs;
    assign obs = {zero, ovf, unf, tag_out, exp_out, mant_out};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [38:0] pk(input logic z, input logic o, input logic u,
                                       input logic [3:0] t, input logic [7:0] e,
                                       input logic [23:0] m);
        return {z, o, u, t, e, m};
    endfunction

    // Reference: locate MSB, shift right with explicit remainder compare for RNE.
    function automatic logic [38:0] model(input logic [47:0] p, input logic [9:0] ein,
                                          input logic [3:0] t);
        longint unsigned pv, q, rem, half;
        int k, sh, e;
        if (p == 48'd0) return pk(1'b1, 1'b0, 1'b0, t, 8'd0, 24'd0);
        pv = 64'(p);
        k = 47;
        while (p[k] == 1'b0) k--;
        e = int'($signed(ein)) + k - 46;
        sh = k - 23;
        if (sh > 0) begin
            q    = pv >> sh;
            rem  = pv & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = pv << (-sh);
        end
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e > 254) return pk(1'b0, 1'b1, 1'b0, t, 8'hFF, 24'd0);
        if (e <= 0) return pk(1'b0, 1'b0, 1'b1, t, 8'd0, 24'd0);
        return pk(1'b0, 1'b0, 1'b0, t, e[7:0], q[23:0]);
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the input.
    task automatic send(input logic [47:0] p, input logic [9:0] e, input logic [3:0] t,
                        input logic [38:0] want);
        int cyc;
        logic acc;
        p_in = p; exp_in = e; tag_in = t; in_valid = 1'b1;
        exp_q.push_back(want);
        n_sent++;
        cyc = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!acc && cyc < 100);
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 60) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_out", 64'd1, 64'd0);
            else chk($sformatf("res%0d", n_out), 64'(obs), 64'(exp_q.pop_front()));
            n_out++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    localparam logic [47:0] P46 = 48'h4000_0000_0000;
    localparam logic [47:0] P47 = 48'h8000_0000_0000;

    logic [38:0] want_a;
    logic [47:0] rp;
    logic [9:0]  re;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; p_in = '0; exp_in = '0; tag_in = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_state", 64'({out_valid, obs}), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: valid appears on the second edge after the accepting edge's cycle.
        send(P46, 10'd127, 4'h1, pk(1'b0, 1'b0, 1'b0, 4'h1, 8'd127, 24'h800000));
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Directed vectors, back to back.
        send(P47, 10'd127, 4'h2, pk(1'b0, 1'b0, 1'b0, 4'h2, 8'd128, 24'h800000));
        send(48'h2000_0000_0000, 10'd1, 4'h3, pk(1'b0, 1'b0, 1'b1, 4'h3, 8'd0, 24'd0));
        send(48'h4000_0040_0000, 10'd127, 4'h4, pk(1'b0, 1'b0, 1'b0, 4'h4, 8'd127, 24'h800000));
        send(48'h4000_00C0_0000, 10'd127, 4'h5, pk(1'b0, 1'b0, 1'b0, 4'h5, 8'd127, 24'h800002));
        send(48'h4000_0040_0001, 10'd127, 4'h6, pk(1'b0, 1'b0, 1'b0, 4'h6, 8'd127, 24'h800001));
        send(48'h7FFF_FFFF_FFFF, 10'd127, 4'h7, pk(1'b0, 1'b0, 1'b0, 4'h7, 8'd128, 24'h800000));
        send(48'h7FFF_FFFF_FFFF, 10'd253, 4'h8, pk(1'b0, 1'b0, 1'b0, 4'h8, 8'd254, 24'h800000));
        send(48'h7FFF_FFFF_FFFF, 10'd254, 4'h9, pk(1'b0, 1'b1, 1'b0, 4'h9, 8'hFF, 24'd0));
        send(48'd0, 10'd77, 4'hA, pk(1'b1, 1'b0, 1'b0, 4'hA, 8'd0, 24'd0));
        send(P46, 10'd1, 4'hB, pk(1'b0, 1'b0, 1'b0, 4'hB, 8'd1, 24'h800000));
        send(P46, 10'd0, 4'hC, pk(1'b0, 1'b0, 1'b1, 4'hC, 8'd0, 24'd0));
        send(P47, 10'h3FB, 4'hD, pk(1'b0, 1'b0, 1'b1, 4'hD, 8'd0, 24'd0));
        send(48'd1, 10'd200, 4'hE, pk(1'b0, 1'b0, 1'b0, 4'hE, 8'd154, 24'h800000));
        in_valid = 1'b0;
        drain();

        // Random back-to-back stream against the reference model.
        for (int i = 0; i < 8; i++) begin
            rp = {16'($urandom), 32'($urandom)};
            re = 10'($urandom_range(100, 160));
            send(rp, re, 4'(i), model(rp, re, 4'(i)));
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: two accepted, third held upstream, outputs frozen.
        out_ready = 1'b0;
        want_a = pk(1'b0, 1'b0, 1'b0, 4'hA, 8'd100, 24'h800000);
        send(P46, 10'd100, 4'hA, want_a);
        send(P46, 10'd101, 4'hB, pk(1'b0, 1'b0, 1'b0, 4'hB, 8'd101, 24'h800000));
        p_in = P46; exp_in = 10'd102; tag_in = 4'hC; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold", 64'({out_valid, obs}), 64'({1'b1, want_a}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(P46, 10'd102, 4'hC, pk(1'b0, 1'b0, 1'b0, 4'hC, 8'd102, 24'h800000));
        send(P46, 10'd103, 4'hD, pk(1'b0, 1'b0, 1'b0, 4'hD, 8'd103, 24'h800000));
        in_valid = 1'b0;
        drain();

        // Reset mid-stream discards in-flight data.
        out_ready = 1'b0;
        send(P46, 10'd50, 4'h1, pk(1'b0, 1'b0, 1'b0, 4'h1, 8'd50, 24'h800000));
        send(P46, 10'd51, 4'h2, pk(1'b0, 1'b0, 1'b0, 4'h2, 8'd51, 24'h800000));
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_data", 64'(obs), 64'd0);
        exp_q.delete();
        n_sent -= 2;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(48'h4000_00C0_0000, 10'd10, 4'h9, pk(1'b0, 1'b0, 1'b0, 4'h9, 8'd10, 24'h800002));
        in_valid = 1'b0;
        drain();
        chk("result_count", 64'(n_out), 64'(n_sent));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
